// File: rtl/data_mem_access_ctrl.sv
// MEM-stage data memory sequencer: decodes load/store codes, drives a
// busywait-style data memory, aligns/extends load data and freezes the
// pipeline while an access is in flight.
module data_mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MEM_ALU_OUT,
  input  logic [31:0] MEM_REG_DATA2,
  input  logic [3:0]  MEM_DATA_MEM_READ,
  input  logic [2:0]  MEM_DATA_MEM_WRITE,
  input  logic        DMEM_BUSYWAIT,
  input  logic [31:0] DMEM_READDATA,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WRITEDATA,
  output logic [3:0]  DMEM_BYTE_EN,
  output logic [31:0] LOAD_DATA,
  output logic        STALL,
  output logic        ACCESS_FAULT,
  output logic        TIMEOUT_FAULT
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [2:0]           funct3_q;
  logic [1:0]           offset_q;

  logic       rd_en, wr_en, any_req, code_ok, misaligned, legal_req, bad_req;
  logic [1:0] size;
  logic       timeout_hit;

  // Byte lane enables for a given access size and byte offset.
  function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_enables = 4'(4'b0001 << off);
      2'b01:   lane_enables = off[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane the size could land on.
  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  // Shift the addressed lane down and sign/zero-extend according to funct3.
  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic        [31:0] lane;
    logic signed [31:0] ext;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  begin ext = $signed(lane[7:0]);  load_align = ext; end
      3'b001:  begin ext = $signed(lane[15:0]); load_align = ext; end
      3'b100:  load_align = {24'h0, lane[7:0]};
      3'b101:  load_align = {16'h0, lane[15:0]};
      default: load_align = lane;
    endcase
  endfunction

  // Request decode: legality of the code and natural alignment of the address.
  always_comb begin
    rd_en   = MEM_DATA_MEM_READ[3];
    wr_en   = MEM_DATA_MEM_WRITE[2];
    any_req = rd_en | wr_en;
    size    = rd_en ? MEM_DATA_MEM_READ[1:0] : MEM_DATA_MEM_WRITE[1:0];
    code_ok = 1'b0;
    if (rd_en && !wr_en) begin
      case (MEM_DATA_MEM_READ[2:0])
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: code_ok = 1'b1;
        default:                                code_ok = 1'b0;
      endcase
    end else if (wr_en && !rd_en) begin
      code_ok = (MEM_DATA_MEM_WRITE[1:0] != 2'b11);
    end
    misaligned = ((size == 2'b01) && MEM_ALU_OUT[0]) ||
                 ((size == 2'b10) && (MEM_ALU_OUT[1:0] != 2'b00));
    legal_req  = any_req && code_ok && !misaligned;
    bad_req    = any_req && !legal_req;
  end

  assign timeout_hit = (state == ACCESS) && DMEM_BUSYWAIT &&
                       (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and combinational stall; stall is held low while in reset.
  always_comb begin
    state_nxt = state;
    STALL     = 1'b0;
    case (state)
      IDLE: begin
        if (legal_req) begin
          STALL     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        STALL = 1'b1;
        if (!DMEM_BUSYWAIT || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!RESET) STALL = 1'b0;
  end

  // Memory request registers, wait counter, load result and fault pulses.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DMEM_READ      <= 1'b0;
      DMEM_WRITE     <= 1'b0;
      DMEM_ADDR      <= '0;
      DMEM_WRITEDATA <= '0;
      DMEM_BYTE_EN   <= '0;
      LOAD_DATA      <= '0;
      ACCESS_FAULT   <= 1'b0;
      TIMEOUT_FAULT  <= 1'b0;
      wait_cnt       <= '0;
      funct3_q       <= '0;
      offset_q       <= '0;
    end else begin
      ACCESS_FAULT  <= (state == IDLE) && bad_req;
      TIMEOUT_FAULT <= timeout_hit;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (legal_req) begin
            DMEM_READ      <= rd_en;
            DMEM_WRITE     <= wr_en;
            DMEM_ADDR      <= {MEM_ALU_OUT[31:2], 2'b00};
            DMEM_BYTE_EN   <= lane_enables(size, MEM_ALU_OUT[1:0]);
            DMEM_WRITEDATA <= store_lanes(size, MEM_REG_DATA2);
            funct3_q       <= MEM_DATA_MEM_READ[2:0];
            offset_q       <= MEM_ALU_OUT[1:0];
          end
        end
        ACCESS: begin
          if (!DMEM_BUSYWAIT) begin
            if (DMEM_READ) LOAD_DATA <= load_align(DMEM_READDATA, offset_q, funct3_q);
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
            wait_cnt   <= '0;
          end else if (timeout_hit) begin
            LOAD_DATA  <= '0;
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
            wait_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Directed bench for data_mem_access_ctrl with hand-computed expectations.
module tb_data_mem_access_ctrl;

  logic        CLK;
  logic        RESET;
  logic [31:0] MEM_ALU_OUT;
  logic [31:0] MEM_REG_DATA2;
  logic [3:0]  MEM_DATA_MEM_READ;
  logic [2:0]  MEM_DATA_MEM_WRITE;
  logic        DMEM_BUSYWAIT;
  logic [31:0] DMEM_READDATA;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WRITEDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic [31:0] LOAD_DATA;
  logic        STALL;
  logic        ACCESS_FAULT;
  logic        TIMEOUT_FAULT;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by run_access.
  int          stall_cnt, acc_cnt;
  logic        obs_rd, obs_wr, held_ok;
  logic [31:0] obs_addr, obs_wd;
  logic [3:0]  obs_be;

  data_mem_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_REG_DATA2(MEM_REG_DATA2),
    .MEM_DATA_MEM_READ(MEM_DATA_MEM_READ), .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .DMEM_READDATA(DMEM_READDATA),
    .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WRITEDATA(DMEM_WRITEDATA), .DMEM_BYTE_EN(DMEM_BYTE_EN),
    .LOAD_DATA(LOAD_DATA), .STALL(STALL),
    .ACCESS_FAULT(ACCESS_FAULT), .TIMEOUT_FAULT(TIMEOUT_FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    MEM_DATA_MEM_READ  = 4'b0000;
    MEM_DATA_MEM_WRITE = 3'b000;
    MEM_ALU_OUT        = 32'h0;
    MEM_REG_DATA2      = 32'h0;
  endtask

  // Present one request in IDLE (called at a falling edge), keep BUSYWAIT
  // high for busy_n ACCESS cycles, and return at the falling edge of DONE
  // with the request inputs cleared.
  task automatic run_access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [31:0] rdata, input int busy_n);
    MEM_DATA_MEM_READ  = rd;
    MEM_DATA_MEM_WRITE = wr;
    MEM_ALU_OUT        = addr;
    MEM_REG_DATA2      = rs2;
    DMEM_READDATA      = rdata;
    DMEM_BUSYWAIT      = 1'b1;
    #1;
    stall_cnt = STALL ? 1 : 0;
    acc_cnt   = 0;
    held_ok   = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (DMEM_READ || DMEM_WRITE) begin
        if (acc_cnt == 0) begin
          obs_rd = DMEM_READ; obs_wr = DMEM_WRITE;
          obs_addr = DMEM_ADDR; obs_be = DMEM_BYTE_EN; obs_wd = DMEM_WRITEDATA;
        end else if (DMEM_ADDR !== obs_addr || DMEM_BYTE_EN !== obs_be ||
                     DMEM_WRITEDATA !== obs_wd) begin
          held_ok = 1'b0;
        end
        acc_cnt++;
      end
      DMEM_BUSYWAIT = (c < busy_n);
      #1;
      if (STALL) stall_cnt++;
      else break;
    end
    clear_inputs();
  endtask

  initial begin
    RESET = 1'b0;
    clear_inputs();
    DMEM_BUSYWAIT = 1'b0;
    DMEM_READDATA = 32'h0;
    obs_rd = 1'b0; obs_wr = 1'b0; obs_addr = 32'h0; obs_be = 4'h0; obs_wd = 32'h0;
    repeat (2) @(negedge CLK);
    check("rst_read",  DMEM_READ, 1'b0);
    check("rst_write", DMEM_WRITE, 1'b0);
    check("rst_addr",  DMEM_ADDR, 32'h0);
    check("rst_load",  LOAD_DATA, 32'h0);
    check("rst_stall", STALL, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);

    // LW 0x100 with immediate completion.
    run_access(4'b1010, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_stall_cycles", stall_cnt, 2);
    check("lw_access_cycles", acc_cnt, 1);
    check("lw_rd", obs_rd, 1'b1);
    check("lw_wr", obs_wr, 1'b0);
    check("lw_addr", obs_addr, 32'h100);
    check("lw_be", obs_be, 4'b1111);
    check("lw_load", LOAD_DATA, 32'hDEADBEEF);
    check("lw_done_stall", STALL, 1'b0);
    @(negedge CLK);

    // LB / LBU at 0x103.
    run_access(4'b1000, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
    check("lb_be", obs_be, 4'b1000);
    check("lb_addr", obs_addr, 32'h100);
    check("lb_load", LOAD_DATA, 32'hFFFFFF80);
    @(negedge CLK);
    run_access(4'b1100, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
    check("lbu_load", LOAD_DATA, 32'h00000080);
    @(negedge CLK);

    // LH / LHU at 0x102.
    run_access(4'b1001, 3'b000, 32'h102, 32'h0, 32'h80FF_0000, 0);
    check("lh_be", obs_be, 4'b1100);
    check("lh_load", LOAD_DATA, 32'hFFFF80FF);
    @(negedge CLK);
    run_access(4'b1101, 3'b000, 32'h102, 32'h0, 32'h80FF_0000, 0);
    check("lhu_load", LOAD_DATA, 32'h000080FF);
    @(negedge CLK);

    // SH 0x22 with three busy cycles; LOAD_DATA must keep the last load.
    run_access(4'b0000, 3'b101, 32'h22, 32'h1234ABCD, 32'h5555_5555, 3);
    check("sh_wd", obs_wd, 32'hABCDABCD);
    check("sh_be", obs_be, 4'b1100);
    check("sh_wr", obs_wr, 1'b1);
    check("sh_rd", obs_rd, 1'b0);
    check("sh_access_cycles", acc_cnt, 4);
    check("sh_stall_cycles", stall_cnt, 5);
    check("sh_held", held_ok, 1'b1);
    check("sh_load_kept", LOAD_DATA, 32'h000080FF);
    @(negedge CLK);

    // SB 0x21 and SW 0x40.
    run_access(4'b0000, 3'b100, 32'h21, 32'hCAFE_F00D, 32'h0, 1);
    check("sb_wd", obs_wd, 32'h0D0D0D0D);
    check("sb_be", obs_be, 4'b0010);
    @(negedge CLK);
    run_access(4'b0000, 3'b110, 32'h40, 32'hCAFE_F00D, 32'h0, 0);
    check("sw_wd", obs_wd, 32'hCAFEF00D);
    check("sw_be", obs_be, 4'b1111);
    @(negedge CLK);

    // Misaligned LW, then READ+WRITE both set: fault pulse, no request.
    MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h102;
    #1 check("mis_stall", STALL, 1'b0);
    @(negedge CLK);
    check("mis_fault", ACCESS_FAULT, 1'b1);
    check("mis_no_read", DMEM_READ, 1'b0);
    clear_inputs();
    @(negedge CLK);
    check("mis_fault_pulse", ACCESS_FAULT, 1'b0);
    MEM_DATA_MEM_READ = 4'b1010; MEM_DATA_MEM_WRITE = 3'b110; MEM_ALU_OUT = 32'h100;
    #1 check("both_stall", STALL, 1'b0);
    @(negedge CLK);
    check("both_fault", ACCESS_FAULT, 1'b1);
    check("both_no_read", DMEM_READ, 1'b0);
    check("both_no_write", DMEM_WRITE, 1'b0);
    clear_inputs();
    @(negedge CLK);
    check("both_fault_pulse", ACCESS_FAULT, 1'b0);

    // BUSYWAIT stuck high: abort after 16 ACCESS cycles.
    run_access(4'b1010, 3'b000, 32'h200, 32'h0, 32'h0, 1000);
    check("to_access_cycles", acc_cnt, 16);
    check("to_stall_cycles", stall_cnt, 17);
    check("to_fault", TIMEOUT_FAULT, 1'b1);
    check("to_load_zero", LOAD_DATA, 32'h0);
    check("to_read_clear", DMEM_READ, 1'b0);
    DMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    check("to_fault_pulse", TIMEOUT_FAULT, 1'b0);
    check("to_idle_stall", STALL, 1'b0);

    // Asynchronous reset in the middle of an access.
    MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h300; DMEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    check("rstmid_read_before", DMEM_READ, 1'b1);
    #2 RESET = 1'b0;
    #1;
    check("rstmid_read", DMEM_READ, 1'b0);
    check("rstmid_addr", DMEM_ADDR, 32'h0);
    check("rstmid_be", DMEM_BYTE_EN, 4'h0);
    check("rstmid_stall", STALL, 1'b0);
    clear_inputs();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    run_access(4'b1010, 3'b000, 32'h104, 32'h0, 32'h12345678, 1);
    check("post_rst_addr", obs_addr, 32'h104);
    check("post_rst_load", LOAD_DATA, 32'h12345678);
    check("post_rst_stall_cycles", stall_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
